iterative_div_unit: RTL and testbench

ITERATIVE_DIV_UNIT -- requirements
Module: iterative_div_unit

---
 rtl/iterative_div_unit_if.sv | 28 ++
 rtl/iterative_div_unit.sv | 143 ++++++++++++++
 tb/tb_iterative_div_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/iterative_div_unit_if.sv
// Issue/writeback bundle for iterative_div_unit.
// master: the pipeline side that offers operations and takes results.
// slave : the divider.
interface iterative_div_unit_if #(
  parameter int ID_W = 3
);
  logic            flush;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      fn3;
  logic [31:0]     rs1;
  logic [31:0]     rs2;
  logic [ID_W-1:0] issue_id;
  logic            wb_valid;
  logic            wb_ack;
  logic [31:0]     wb_rd;
  logic [ID_W-1:0] wb_id;

  modport master (
    output flush, issue_valid, fn3, rs1, rs2, issue_id, wb_ack,
    input  issue_ready, wb_valid, wb_rd, wb_id
  );

  modport slave (
    input  flush, issue_valid, fn3, rs1, rs2, issue_id, wb_ack,
    output issue_ready, wb_valid, wb_rd, wb_id
  );
endinterface

// File: rtl/iterative_div_unit.sv
// Restoring radix-2 divider for the RISC-V M-extension DIV/DIVU/REM/REMU ops.
// One quotient bit per BUSY cycle; the result is held in DONE until wb_ack.
// Optional macro DIV_EARLY_TERMINATE_EN: divide-by-zero and signed overflow
// skip BUSY and go straight to DONE on the accepting edge.
//
// state | meaning
// IDLE  | ready for an operation
// BUSY  | conditioning cycle, then 32 restoring steps
// DONE  | result valid, waiting for wb_ack
module iterative_div_unit #(
  parameter int ID_W = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  iterative_div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [4:0]      cnt;
  logic            prep;
  logic            sel_rem;
  logic            is_signed;
  logic            neg_q;
  logic            neg_r;
  logic [ID_W-1:0] id_q;
  logic [31:0]     quo;
  logic [31:0]     dvs;
  logic [31:0]     rem;
  logic [31:0]     rd_q;

  logic [32:0]     trial;
  logic [31:0]     rem_nxt;
  logic [31:0]     quo_nxt;
  logic [31:0]     res;
  logic            unused_fn3_msb;

  assign unused_fn3_msb  = bus.fn3[2];
  assign bus.issue_ready = (state == IDLE);
  assign bus.wb_valid    = (state == DONE);
  assign bus.wb_rd       = rd_q;
  assign bus.wb_id       = id_q;

  // One restoring step plus the sign fix-up applied on the final step.
  always_comb begin
    trial = {rem, quo[31]} - {1'b0, dvs};
    if (!trial[32]) begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = {rem[30:0], quo[31]};
      quo_nxt = {quo[30:0], 1'b0};
    end
    if (sel_rem) res = neg_r ? -rem_nxt : rem_nxt;
    else         res = neg_q ? -quo_nxt : quo_nxt;
  end

`ifdef DIV_EARLY_TERMINATE_EN
  logic        dbz;
  logic        ovf;
  logic [31:0] early_rd;

  // Fixed results for the two cases that need no iteration.
  always_comb begin
    dbz = (bus.rs2 == 32'd0);
    ovf = !bus.fn3[0] && (bus.rs1 == 32'h8000_0000) && (bus.rs2 == 32'hFFFF_FFFF);
    if (bus.fn3[1]) early_rd = dbz ? bus.rs1 : 32'd0;
    else            early_rd = dbz ? 32'hFFFF_FFFF : 32'h8000_0000;
  end
`endif

  // Control FSM and datapath registers; flush overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      prep      <= 1'b0;
      sel_rem   <= 1'b0;
      is_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      id_q      <= '0;
      quo       <= 32'd0;
      dvs       <= 32'd0;
      rem       <= 32'd0;
      rd_q      <= 32'd0;
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
      prep  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.issue_valid) begin
            sel_rem   <= bus.fn3[1];
            is_signed <= !bus.fn3[0];
            neg_q     <= !bus.fn3[0] && (bus.rs1[31] ^ bus.rs2[31]) && (bus.rs2 != 32'd0);
            neg_r     <= !bus.fn3[0] && bus.rs1[31];
            id_q      <= bus.issue_id;
            quo       <= bus.rs1;
            dvs       <= bus.rs2;
            cnt       <= 5'd0;
            prep      <= 1'b1;
            state     <= BUSY;
`ifdef DIV_EARLY_TERMINATE_EN
            if (dbz || ovf) begin
              prep  <= 1'b0;
              rd_q  <= early_rd;
              state <= DONE;
            end
`endif
          end
        end
        BUSY: begin
          // The first BUSY cycle takes magnitudes so the negate adders stay
          // off the issue path; the 32 steps follow.
          if (prep) begin
            quo  <= (is_signed && quo[31]) ? -quo : quo;
            dvs  <= (is_signed && dvs[31]) ? -dvs : dvs;
            rem  <= 32'd0;
            prep <= 1'b0;
          end else begin
            quo <= quo_nxt;
            rem <= rem_nxt;
            if (cnt == 5'd31) begin
              rd_q  <= res;
              cnt   <= 5'd0;
              state <= DONE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        DONE: begin
          if (bus.wb_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_div_unit.sv
// Self-checking bench for iterative_div_unit: directed cases with literal
// results, flush/reset aborts, then randomized traffic against an
// arithmetic reference model.
module tb_iterative_div_unit;
  localparam int ID_W = 3;
  localparam int LAT  = 33;
`ifdef DIV_EARLY_TERMINATE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  iterative_div_unit_if #(.ID_W(ID_W)) bus ();
  iterative_div_unit #(.ID_W(ID_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit              m_busy  = 1'b0;
  bit              m_valid = 1'b0;
  int              m_left  = 0;
  logic [31:0]     m_rd    = 32'd0;
  logic [ID_W-1:0] m_id    = '0;

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f[1] ? r : q;
  endfunction

  function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: transaction-level view of what the unit must be doing.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy = 1'b0; m_valid = 1'b0;
    end else if (bus.flush) begin
      m_busy = 1'b0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (bus.wb_ack) m_valid = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_valid = 1'b1;
      end
    end else if (bus.issue_valid) begin
      m_rd = ref_div(bus.fn3, bus.rs1, bus.rs2);
      m_id = bus.issue_id;
      if (EARLY && special(bus.fn3, bus.rs1, bus.rs2)) m_valid = 1'b1;
      else begin
        m_busy = 1'b1; m_left = LAT;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("issue_ready", 32'(bus.issue_ready), 32'(!m_busy && !m_valid));
      chk("wb_valid", 32'(bus.wb_valid), 32'(m_valid));
      if (m_valid) begin
        chk("wb_rd", bus.wb_rd, m_rd);
        chk("wb_id", 32'(bus.wb_id), 32'(m_id));
      end
    end
  end

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.wb_ack = 1'b0;
    bus.fn3 = 3'd0; bus.rs1 = 32'd0; bus.rs2 = 32'd0; bus.issue_id = '0;
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!bus.issue_ready && k < 100) begin
      @(negedge clk); k++;
    end
    ok = bus.issue_ready;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: issue_ready stayed 0 for %0d cycles", k);
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [ID_W-1:0] id, input logic [31:0] exp, input int hold);
    bit ok;
    int t0, k, lat;
    lat = (EARLY && special(f, a, b)) ? 0 : LAT;
    wait_ready(ok);
    if (!ok) return;
    bus.fn3 = f; bus.rs1 = a; bus.rs2 = b; bus.issue_id = id; bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    t0 = cyc;
    k = 0;
    while (!bus.wb_valid && k < 60) begin
      @(negedge clk); k++;
    end
    if (!bus.wb_valid) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: wb_valid 0 after %0d cycles, expected latency %0d", k, lat);
      return;
    end
    chk("latency", 32'(cyc - t0), 32'(lat));
    chk("result", bus.wb_rd, exp);
    chk("tag", 32'(bus.wb_id), 32'(id));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_valid", 32'(bus.wb_valid), 32'd1);
      chk("hold_rd", bus.wb_rd, exp);
      chk("hold_id", 32'(bus.wb_id), 32'(id));
      chk("hold_ready", 32'(bus.issue_ready), 32'd0);
    end
    bus.wb_ack = 1'b1;
    @(negedge clk);
    bus.wb_ack = 1'b0;
    chk("after_ack_valid", 32'(bus.wb_valid), 32'd0);
    chk("after_ack_ready", 32'(bus.issue_ready), 32'd1);
  endtask

  task automatic abort_op(input bit use_reset, input int at);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.fn3 = 3'b101; bus.rs1 = 32'd1000; bus.rs2 = 32'd3; bus.issue_id = 3'd5;
    bus.issue_valid = 1'b1;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    repeat (at - 1) @(negedge clk);
    if (use_reset) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(bus.issue_ready), 32'd1);
      chk("rst_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_rd", bus.wb_rd, 32'd0);
      chk("rst_id", 32'(bus.wb_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_valid", 32'(bus.wb_valid), 32'd0);
      chk("flush_ready", 32'(bus.issue_ready), 32'd1);
    end
    repeat (40) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle_inputs();
    #3 rst_n = 1'b0;
    #1;
    chk("reset_ready", 32'(bus.issue_ready), 32'd1);
    chk("reset_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_rd", bus.wb_rd, 32'd0);
    chk("reset_id", 32'(bus.wb_id), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'b101, 32'd100,         32'd7,         3'd2, 32'd14,         0);
    do_op(3'b110, 32'hFFFF_FF9C,   32'd7,         3'd1, 32'hFFFF_FFFE,  0);
    do_op(3'b100, 32'hFFFF_FF9C,   32'd7,         3'd3, 32'hFFFF_FFF2,  0);
    do_op(3'b100, 32'hFFFF_FFF9,   32'd0,         3'd4, 32'hFFFF_FFFF,  0);
    do_op(3'b111, 32'd5,           32'd0,         3'd5, 32'd5,          0);
    do_op(3'b100, 32'h8000_0000,   32'hFFFF_FFFF, 3'd6, 32'h8000_0000,  0);
    do_op(3'b110, 32'h8000_0000,   32'hFFFF_FFFF, 3'd7, 32'd0,          0);
    do_op(3'b111, 32'd100,         32'd7,         3'd3, 32'd2,          10);
    do_op(3'b001, 32'd100,         32'd7,         3'd6, 32'd14,         0);

    abort_op(1'b0, 15);
    do_op(3'b101, 32'd9, 32'd3, 3'd1, 32'd3, 0);
    abort_op(1'b1, 12);
    do_op(3'b101, 32'd9, 32'd3, 3'd2, 32'd3, 0);

    repeat (4000) begin
      @(negedge clk);
      bus.issue_valid = ($urandom_range(0, 3) != 0);
      bus.fn3         = 3'($urandom_range(0, 7));
      bus.rs1         = pick();
      bus.rs2         = pick();
      bus.issue_id    = ID_W'($urandom_range(0, (1 << ID_W) - 1));
      bus.wb_ack      = ($urandom_range(0, 3) == 0);
      bus.flush       = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    idle_inputs();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
